mem_port_arbiter_3: RTL and testbench
=====================================

MEM_PORT_ARBITER_3 -- requirements
Module: mem_port_arbiter_3

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, BUSY-cycle limit before abort; used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  3  per-requester level request; bit i = requester i.
REQ-005 Port: mem_done  input  1  one-cycle pulse from the shared port when the current transaction completes.
REQ-006 Port: gnt  output  3  registered one-hot grant; zero when no grant is active.
REQ-007 Port: sel  output  2  registered select for the shared 3:1 operand mux; encoding 00=req0, 01=req1, 10=req2, 11=none (mux outputs zero).
REQ-008 Port: mem_valid  output  1  registered; high while a transaction is presented to the shared port.
REQ-009 Port: ack  output  3  registered one-cycle completion pulse to the granted requester.
REQ-010 Port: err  output  1  registered one-cycle abort pulse, coincident with ack; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 IDLE outputs SHALL be: gnt=000, sel=11, mem_valid=0, ack=000.
REQ-013 In IDLE with req!=0, the next cycle SHALL be BUSY with the winner latched; grant latency is one cycle from req being sampled.
REQ-014 Winner selection SHALL be round-robin: priority order starts at (last+1) mod 3 and wraps, where last is the index of the most recently completed grant.
REQ-015 In BUSY: gnt=one-hot(winner), sel=binary(winner), mem_valid=1, all held stable until exit.
REQ-016 In BUSY with mem_done=1, the next state SHALL be DONE and last SHALL be set to the winner.
REQ-017 DONE SHALL last exactly one cycle, with ack[winner]=1, gnt=000, sel=11, mem_valid=0, then go to IDLE.
REQ-018 req SHALL be ignored in BUSY and DONE, so a requester dropping req in its ack cycle is never re-granted.
REQ-019 Withdrawal of req during BUSY SHALL NOT abort the transaction.
REQ-020 mem_done SHALL be ignored in IDLE and DONE.
REQ-021 The minimum transaction spacing SHALL be 3 cycles (IDLE, BUSY, DONE) when mem_done arrives in the first BUSY cycle.
REQ-022 sel=11 SHALL never coincide with mem_valid=1.
REQ-023 gnt SHALL never have more than one bit set.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, gnt=000, sel=11, mem_valid=0, ack=000, err=0 and last=2 (req0 has first priority), regardless of clock.
REQ-025 Reset asserted mid-BUSY SHALL drop the transaction without an ack or err pulse.
REQ-026 After rst deasserts, the first arbitration SHALL occur on the first rising edge at which req!=0.

Configuration
REQ-027 The macro ARB_TIMEOUT_EN SHALL, when defined, include a BUSY-cycle counter that clears on BUSY entry and increments each BUSY cycle.
REQ-028 With ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without mem_done, the FSM SHALL enter DONE with ack[winner]=1 and err=1, and last SHALL advance to the winner.
REQ-029 With ARB_TIMEOUT_EN defined, if mem_done arrives in the same cycle the limit is reached, the transaction SHALL complete normally (err=0).
REQ-030 Without ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be constant 0, and BUSY SHALL wait indefinitely.

Verification
REQ-031 Single request: after reset, req=001 -> next cycle gnt=001, sel=00, mem_valid=1; mem_done pulse -> next cycle ack=001, sel=11; following cycle IDLE.
REQ-032 Contention fairness: req=111 held, mem_done one cycle after each grant -> grant order 0,1,2,0,1,2 with sel sequence 00,01,10,00.
REQ-033 Ignored inputs: mem_done pulse in IDLE -> no state change; req=010 asserted during a req0 BUSY -> req1 granted only after DONE.
REQ-034 Async reset: rst pulse mid-BUSY, between clock edges -> outputs return to IDLE values before the next edge; no ack or err pulse.
REQ-035 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=100 with no mem_done -> after 4 BUSY cycles, ack=100 and err=1 for one cycle; next req=111 grants requester 0.
REQ-036 Build without ARB_TIMEOUT_EN: req=001, mem_done withheld 1000 cycles -> mem_valid remains 1 and err remains 0.

Source files
------------

// File: rtl/mem_port_arbiter_3.sv
// rtl/mem_port_arbiter_3.sv - 3-requester round-robin arbiter for a shared memory port (optional BUSY timeout under ARB_TIMEOUT_EN)
//
// Flow per transaction: IDLE -> BUSY (grant held until mem_done) -> DONE (one-cycle ack) -> IDLE.
// All outputs are registered and change together with the state.
// Define ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT_CYCLES cycles with ack+err.

module mem_port_arbiter_3 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       mem_done,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic [2:0] ack,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b11;

    state_t     state;
    logic [1:0] winner;
    logic [1:0] last;
    logic [1:0] next_winner;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] busy_cnt;
    logic          limit_hit;

    // The counter holds the number of BUSY cycles already completed, so the
    // limit is reached during the TIMEOUT_CYCLES-th BUSY cycle.
    assign limit_hit = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Round-robin pick: search starts one past the last completed grant and wraps.
    always_comb begin
        next_winner = 2'd0;
        case (last)
            2'd0: begin
                if (req[1])      next_winner = 2'd1;
                else if (req[2]) next_winner = 2'd2;
                else             next_winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      next_winner = 2'd2;
                else if (req[0]) next_winner = 2'd0;
                else             next_winner = 2'd1;
            end
            default: begin
                if (req[0])      next_winner = 2'd0;
                else if (req[1]) next_winner = 2'd1;
                else             next_winner = 2'd2;
            end
        endcase
    end

    // Arbitration FSM with registered outputs; req is only looked at in IDLE,
    // mem_done only in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= 2'd0;
            last      <= 2'd2;
            gnt       <= 3'b000;
            sel       <= SEL_NONE;
            mem_valid <= 1'b0;
            ack       <= 3'b000;
            err       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack <= 3'b000;
                    err <= 1'b0;
                    if (req != 3'b000) begin
                        state     <= BUSY;
                        winner    <= next_winner;
                        gnt       <= 3'b001 << next_winner;
                        sel       <= next_winner;
                        mem_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        busy_cnt  <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (mem_done) begin
                        // Normal completion wins even when the limit is hit this cycle.
                        state     <= DONE;
                        last      <= winner;
                        ack       <= 3'b001 << winner;
                        err       <= 1'b0;
                        gnt       <= 3'b000;
                        sel       <= SEL_NONE;
                        mem_valid <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (limit_hit) begin
                        state     <= DONE;
                        last      <= winner;
                        ack       <= 3'b001 << winner;
                        err       <= 1'b1;
                        gnt       <= 3'b000;
                        sel       <= SEL_NONE;
                        mem_valid <= 1'b0;
                    end else begin
                        busy_cnt  <= busy_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    state <= IDLE;
                    ack   <= 3'b000;
                    err   <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    gnt       <= 3'b000;
                    sel       <= SEL_NONE;
                    mem_valid <= 1'b0;
                    ack       <= 3'b000;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter_3.sv
// tb/tb_mem_port_arbiter_3.sv - randomized and directed bench for mem_port_arbiter_3 against a transaction-level model

module tb_mem_port_arbiter_3;

    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       mem_done = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic [2:0] ack;
    logic       err;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter_3 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .mem_done(mem_done),
        .gnt(gnt), .sel(sel), .mem_valid(mem_valid), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the port (-1 none), who is being acked (-1 none).
    int m_owner, m_ack, m_last, m_busy;
    bit m_err;

    function automatic int pick(input logic [2:0] r, input int l);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (l + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Model update at the clock edge, reset acts immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1; m_ack <= -1; m_err <= 1'b0; m_last <= 2; m_busy <= 0;
        end else if (m_ack >= 0) begin
            m_ack <= -1; m_err <= 1'b0;
        end else if (m_owner >= 0) begin
            if (mem_done || (TIMEOUT_ON && (m_busy + 1 == TO))) begin
                m_ack <= m_owner; m_err <= !mem_done; m_last <= m_owner; m_owner <= -1;
            end else begin
                m_busy <= m_busy + 1;
            end
        end else if (req != 3'b000) begin
            m_owner <= pick(req, m_last); m_busy <= 0;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("model_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_sel", sel, (m_owner >= 0) ? m_owner : 3);
        chk("model_mem_valid", mem_valid, (m_owner >= 0) ? 1 : 0);
        chk("model_ack", ack, (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
        chk("model_err", err, m_err);
    end

    task automatic step(input logic [2:0] r, input logic d);
        @(negedge clk);
        req = r;
        mem_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; req = 3'b000; mem_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] exp_gnt_order [6];
    logic [1:0] exp_sel_order [6];

    initial begin
        exp_gnt_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_sel_order = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

        #12;
        chk("reset_gnt", gnt, 3'b000);
        chk("reset_sel", sel, 2'b11);
        chk("reset_valid", mem_valid, 1'b0);
        chk("reset_ack", ack, 3'b000);
        chk("reset_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        step(3'b001, 1'b0);
        chk("single_gnt", gnt, 3'b001);
        chk("single_sel", sel, 2'b00);
        chk("single_valid", mem_valid, 1'b1);
        step(3'b001, 1'b1);
        chk("single_ack", ack, 3'b001);
        chk("single_done_sel", sel, 2'b11);
        chk("single_done_gnt", gnt, 3'b000);
        step(3'b001, 1'b0);
        chk("single_idle_ack", ack, 3'b000);
        chk("single_idle_valid", mem_valid, 1'b0);

        // Fairness under full contention
        pulse_reset();
        for (int n = 0; n < 6; n++) begin
            step(3'b111, 1'b0);
            chk("rr_gnt", gnt, exp_gnt_order[n]);
            chk("rr_sel", sel, exp_sel_order[n]);
            step(3'b111, 1'b1);
            chk("rr_ack", ack, exp_gnt_order[n]);
            step(3'b111, 1'b0);
        end

        // Ignored inputs
        step(3'b000, 1'b1);
        chk("idle_done_valid", mem_valid, 1'b0);
        chk("idle_done_ack", ack, 3'b000);
        step(3'b001, 1'b0);
        chk("ign_gnt0", gnt, 3'b001);
        step(3'b011, 1'b0);
        chk("ign_hold", gnt, 3'b001);
        step(3'b010, 1'b1);
        chk("ign_ack0", ack, 3'b001);
        step(3'b010, 1'b0);
        chk("ign_done_no_gnt", gnt, 3'b000);
        step(3'b010, 1'b0);
        chk("ign_gnt1", gnt, 3'b010);
        step(3'b010, 1'b1);
        step(3'b000, 1'b0);

        // Async reset in the middle of BUSY
        step(3'b100, 1'b0);
        chk("ar_busy", gnt, 3'b100);
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt", gnt, 3'b000);
        chk("ar_sel", sel, 2'b11);
        chk("ar_valid", mem_valid, 1'b0);
        chk("ar_ack", ack, 3'b000);
        chk("ar_err", err, 1'b0);
        rst = 1'b0;
        step(3'b000, 1'b1);
        chk("ar_no_ack", ack, 3'b000);
        chk("ar_no_err", err, 1'b0);

`ifdef ARB_TIMEOUT_EN
        pulse_reset();
        step(3'b100, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(3'b000, 1'b0);
            chk("to_still_busy", mem_valid, 1'b1);
        end
        step(3'b000, 1'b0);
        chk("to_ack", ack, 3'b100);
        chk("to_err", err, 1'b1);
        step(3'b111, 1'b0);
        chk("to_err_clear", err, 1'b0);
        step(3'b111, 1'b0);
        chk("to_next_gnt", gnt, 3'b001);
        // mem_done on the limit cycle completes normally
        for (int n = 0; n < 3; n++) step(3'b000, 1'b0);
        step(3'b000, 1'b1);
        chk("to_race_ack", ack, 3'b001);
        chk("to_race_err", err, 1'b0);
        step(3'b000, 1'b0);
`else
        pulse_reset();
        step(3'b001, 1'b0);
        for (int n = 0; n < 1000; n++) step(3'b000, 1'b0);
        chk("hang_valid", mem_valid, 1'b1);
        chk("hang_err", err, 1'b0);
        pulse_reset();
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            req = 3'($urandom_range(0, 7));
            mem_done = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        rst = 1'b0; req = 3'b000; mem_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
